// File: rtl/byte_serializer_pkg.sv
// Shared constants for the byte serializer: data width, default depth,
// shifter state encoding and the bit-order helper.
package byte_serializer_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEFAULT_DEPTH = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Bit idx of a byte in transmission order.
    function automatic logic pick_bit(
        input logic [BYTE_W-1:0] b,
        input logic [2:0]        idx,
        input logic              msb_first
    );
        return msb_first ? b[3'd7 - idx] : b[idx];
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with power-of-two depth, exact occupancy count and
// synchronous flush; a push coinciding with flush is dropped.
module byte_fifo
    import byte_serializer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              pop_i,
    output logic [BYTE_W-1:0] data_o,
    output logic [CW-1:0]     count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/byte_serializer.sv
// Byte-to-bit serializer: FIFO-buffered bytes shifted out one bit per
// enabled cycle with registered valid/data/busy outputs.
module byte_serializer
    import byte_serializer_pkg::*;
#(
    parameter int   DEPTH     = DEFAULT_DEPTH,
    parameter logic MSB_FIRST = 1'b1,
    localparam int  CW = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              byte_ready_o,
    input  logic              en_i,
    input  logic              flush_i,
    output logic              valid_o,
    output logic              d_o,
    output logic              busy_o,
    output logic [CW-1:0]     fifo_cnt_o
);

    logic [BYTE_W-1:0] fifo_data;
    logic              fifo_full, fifo_empty;
    logic              pop;

    logic [0:0]        state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic              valid_q, valid_d;
    logic              d_q, d_d;
    logic              busy_q, busy_d;

    assign byte_ready_o = ~fifo_full;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (byte_valid_i & byte_ready_o),
        .data_i  (byte_i),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .count_o (fifo_cnt_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        valid_d = 1'b0;
        d_d     = 1'b0;
        busy_d  = busy_q;
        pop     = 1'b0;
        if (flush_i) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (en_i && !fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_data;
                        idx_d   = '0;
                        valid_d = 1'b1;
                        d_d     = pick_bit(fifo_data, 3'd0, MSB_FIRST);
                        busy_d  = 1'b1;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (idx_q == 3'd7) begin
                        // Byte complete: chain the next one or go idle.
                        if (en_i && !fifo_empty) begin
                            pop     = 1'b1;
                            shreg_d = fifo_data;
                            idx_d   = '0;
                            valid_d = 1'b1;
                            d_d     = pick_bit(fifo_data, 3'd0, MSB_FIRST);
                        end else begin
                            state_d = ST_IDLE;
                            idx_d   = '0;
                            busy_d  = 1'b0;
                        end
                    end else if (en_i) begin
                        idx_d   = idx_q + 3'd1;
                        valid_d = 1'b1;
                        d_d     = pick_bit(shreg_q, idx_q + 3'd1, MSB_FIRST);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shreg_q <= '0;
            valid_q <= 1'b0;
            d_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            valid_q <= valid_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
        end
    end

    assign valid_o = valid_q;
    assign d_o     = d_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Directed and randomized-stream bench for byte_serializer
// (DEPTH=4, MSB_FIRST=1).
module tb_byte_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic       byte_ready;
    logic       en;
    logic       flush;
    logic       valid;
    logic       d;
    logic       busy;
    logic [2:0] cnt;

    int checks   = 0;
    int failures = 0;

    byte_serializer #(
        .DEPTH     (4),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .byte_valid_i (byte_valid),
        .byte_i       (byte_in),
        .byte_ready_o (byte_ready),
        .en_i         (en),
        .flush_i      (flush),
        .valid_o      (valid),
        .d_o          (d),
        .busy_o       (busy),
        .fifo_cnt_o   (cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0]  b8;
    logic [15:0] b16;
    logic [31:0] b32;
    bit          exp_q[$];
    int          pushed;
    int          cyc;
    logic        acc;
    logic [7:0]  acc_byte;

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        en         = 1'b0;
        flush      = 1'b0;
        step();
        step();
        check("rst_valid", valid, 0);
        check("rst_d", d, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", cnt, 0);
        check("rst_ready", byte_ready, 1);
        rst = 1'b0;

        // Single byte 0x6D
        b8 = 8'h6D;
        en = 1'b1;
        byte_valid = 1'b1;
        byte_in = b8;
        step();
        byte_valid = 1'b0;
        check("single_cnt", cnt, 1);
        check("single_lat_valid", valid, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("single_valid", valid, 1);
            check("single_bit", d, b8[7-i]);
        end
        step();
        check("single_end_valid", valid, 0);
        check("single_end_d", d, 0);
        check("single_end_busy", busy, 0);

        // Back-to-back 0xA5, 0x3C
        b16 = 16'hA53C;
        byte_valid = 1'b1;
        byte_in = 8'hA5;
        step();
        byte_in = 8'h3C;
        step();
        byte_valid = 1'b0;
        check("b2b_valid", valid, 1);
        check("b2b_bit", d, b16[15]);
        check("b2b_busy", busy, 1);
        for (int i = 1; i < 16; i++) begin
            step();
            check("b2b_valid", valid, 1);
            check("b2b_bit", d, b16[15-i]);
            check("b2b_busy", busy, 1);
        end
        step();
        check("b2b_end_valid", valid, 0);
        check("b2b_end_busy", busy, 0);

        // Full FIFO with shifting paused
        b32 = 32'h11223344;
        en = 1'b0;
        byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            byte_in = b32[31-8*i -: 8];
            step();
        end
        check("full_cnt", cnt, 4);
        check("full_ready", byte_ready, 0);
        byte_in = 8'h55;
        step();
        byte_valid = 1'b0;
        check("full_cnt_5th", cnt, 4);
        check("full_no_valid", valid, 0);
        en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            check("full_valid", valid, 1);
            check("full_bit", d, b32[31-i]);
        end
        step();
        check("full_end_valid", valid, 0);
        check("full_end_cnt", cnt, 0);

        // Pause after the 3rd bit of 0xF0
        b8 = 8'hF0;
        byte_valid = 1'b1;
        byte_in = b8;
        step();
        byte_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("pause_pre_bit", d, b8[7-i]);
            check("pause_pre_valid", valid, 1);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("pause_valid", valid, 0);
            check("pause_d", d, 0);
            check("pause_busy", busy, 1);
        end
        en = 1'b1;
        for (int i = 3; i < 8; i++) begin
            step();
            check("pause_post_valid", valid, 1);
            check("pause_post_bit", d, b8[7-i]);
        end
        step();
        check("pause_end_valid", valid, 0);

        // Flush mid-byte, with a push on the flush edge
        en = 1'b0;
        byte_valid = 1'b1;
        byte_in = 8'hFF; step();
        byte_in = 8'hAA; step();
        byte_in = 8'hBB; step();
        byte_valid = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("flush_pre_bit", d, 1);
        end
        check("flush_pre_cnt", cnt, 2);
        flush = 1'b1;
        byte_valid = 1'b1;
        byte_in = 8'hCC;
        step();
        flush = 1'b0;
        byte_valid = 1'b0;
        check("flush_valid", valid, 0);
        check("flush_busy", busy, 0);
        check("flush_cnt", cnt, 0);
        check("flush_ready", byte_ready, 1);
        step();
        check("flush_after_valid", valid, 0);

        // Reset mid-byte
        en = 1'b0;
        byte_valid = 1'b1;
        byte_in = 8'hFF; step();
        byte_in = 8'hAA; step();
        byte_in = 8'hBB; step();
        byte_valid = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("rst2_pre_cnt", cnt, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_valid", valid, 0);
        check("rst2_busy", busy, 0);
        check("rst2_cnt", cnt, 0);
        check("rst2_ready", byte_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst2_after_valid", valid, 0);
        end

        // Random stream of 20 bytes with random valid/enable
        pushed = 0;
        cyc = 0;
        while (cyc < 3000 && !(pushed == 20 && exp_q.size() == 0)) begin
            byte_valid = (pushed < 20) && ($urandom_range(0, 1) == 1);
            byte_in = 8'($urandom_range(0, 255));
            en = ($urandom_range(0, 3) != 0);
            #1;
            acc = byte_valid && byte_ready;
            acc_byte = byte_in;
            step();
            cyc++;
            if (valid) begin
                if (exp_q.size() == 0) check("rand_extra_bit", 1, 0);
                else check("rand_bit", d, exp_q.pop_front());
            end else begin
                check("rand_idle_d", d, 0);
            end
            check("rand_cnt_le4", cnt <= 3'd4, 1);
            if (acc) begin
                for (int k = 7; k >= 0; k--) exp_q.push_back(acc_byte[k]);
                pushed++;
            end
        end
        byte_valid = 1'b0;
        check("rand_pushed", pushed, 20);
        check("rand_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
